// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: default datapath widths and writeback-stage state type.
package mips_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_WIDTH  = 5;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } wb_state_t;

endpackage

// File: rtl/muxNx1.sv
// Parametrised N-way multiplexer; an out-of-range select yields zero.
module muxNx1 #(
    parameter int N    = 2,
    parameter int W    = 32,
    parameter int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N*W-1:0] dataIn,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]   dataOut
);

    always_comb begin
        dataOut = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(sel) == k) begin
                dataOut = dataIn[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/wb_retire_unit.sv
// Writeback/retire stage: registers the register-file write, counts retired
// instructions and drains the pipeline for a fixed number of cycles after HALT.
module wb_retire_unit
    import mips_pkg::*;
#(
    parameter int DATA          = DATA_WIDTH,
    parameter int REGISTERWIDTH = REG_WIDTH,
    parameter int NSRC          = 2,
    parameter int DRAIN         = 4,
    localparam int SELW         = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     inValid,
    input  logic [REGISTERWIDTH-1:0] inRd,
    input  logic                     inRegWrite,
    input  logic [SELW-1:0]          inSel,
    input  logic [NSRC*DATA-1:0]     inData,
    input  logic                     inHalt,
    output logic                     wbWe,
    output logic [REGISTERWIDTH-1:0] wbRd,
    output logic [DATA-1:0]          wbData,
    output logic [31:0]              retireCount,
    output logic                     selError,
    output logic                     haltDone
);

    // The parameter DRAIN shadows the enum literal, so the state is always package-qualified.
    wb_state_t  state;
    wb_state_t  nextState;
    logic [3:0] drainCnt;
    logic       accept;
    logic       selOk;
    logic       writeEn;
    logic [DATA-1:0] muxOut;

    muxNx1 #(
        .N    (NSRC),
        .W    (DATA),
        .SELW (SELW)
    ) srcMux (
        .dataIn  (inData),
        .sel     (inSel),
        .dataOut (muxOut)
    );

    always_comb begin
        nextState = state;
        accept    = inValid && (state == RUN);
        selOk     = (int'(inSel) < NSRC);
        writeEn   = accept && inRegWrite && (inRd != '0) && !inHalt && selOk;
        case (state)
            RUN: begin
                if (accept && inHalt) nextState = mips_pkg::DRAIN;
            end
            mips_pkg::DRAIN: begin
                if (drainCnt == '0) nextState = HALTED;
            end
            HALTED: nextState = HALTED;
            default: nextState = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= RUN;
            drainCnt    <= '0;
            wbWe        <= 1'b0;
            wbRd        <= '0;
            wbData      <= '0;
            retireCount <= '0;
            selError    <= 1'b0;
        end else begin
            state <= nextState;
            if (accept && inHalt) begin
                drainCnt <= 4'(DRAIN - 1);
            end else if (state == mips_pkg::DRAIN && drainCnt != '0) begin
                drainCnt <= drainCnt - 4'd1;
            end
            wbWe <= writeEn;
            if (writeEn) begin
                wbRd   <= inRd;
                wbData <= muxOut;
            end
            // Saturate rather than wrap so a long run never reports a tiny count.
            if (accept && retireCount != 32'hFFFF_FFFF) begin
                retireCount <= retireCount + 32'd1;
            end
            if (accept && !selOk) begin
                selError <= 1'b1;
            end
        end
    end

    assign haltDone = (state == HALTED);

endmodule

// File: tb/tb_wb_retire_unit.sv
// Self-checking bench for wb_retire_unit (NSRC=3, DRAIN=4) against a cycle-level behavioural model.
module tb_wb_retire_unit;

    localparam int NSRC  = 3;
    localparam int DRAIN = 4;

    logic        clk = 1'b0;
    logic        resetN;
    logic        inValid;
    logic [4:0]  inRd;
    logic        inRegWrite;
    logic [1:0]  inSel;
    logic [95:0] inData;
    logic        inHalt;
    logic        wbWe;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
    logic [31:0] retireCount;
    logic        selError;
    logic        haltDone;

    // Behavioural model of the observable state
    logic        mWe;
    logic [4:0]  mRd;
    logic [31:0] mData;
    logic [31:0] mCount;
    logic        mErr;
    bit          draining;
    bit          halted;
    int          drainLeft;

    int vectors    = 0;
    int miscompares = 0;

    wb_retire_unit #(
        .DATA          (32),
        .REGISTERWIDTH (5),
        .NSRC          (NSRC),
        .DRAIN         (DRAIN)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .inValid     (inValid),
        .inRd        (inRd),
        .inRegWrite  (inRegWrite),
        .inSel       (inSel),
        .inData      (inData),
        .inHalt      (inHalt),
        .wbWe        (wbWe),
        .wbRd        (wbRd),
        .wbData      (wbData),
        .retireCount (retireCount),
        .selError    (selError),
        .haltDone    (haltDone)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, then advance the model over the rising edge.
    task automatic applyStimulus(input logic rstN, input logic v, input logic rw, input logic h,
                                 input logic [4:0] rd, input logic [1:0] sel, input logic [95:0] data);
        int s;
        @(negedge clk);
        resetN     = rstN;
        inValid    = v;
        inRegWrite = rw;
        inHalt     = h;
        inRd       = rd;
        inSel      = sel;
        inData     = data;
        @(posedge clk);
        s = int'(sel);
        if (!rstN) begin
            mWe = 0; mRd = '0; mData = '0; mCount = '0; mErr = 0;
            draining = 0; halted = 0; drainLeft = 0;
        end else if (halted) begin
            mWe = 0;
        end else if (draining) begin
            mWe = 0;
            drainLeft = drainLeft - 1;
            if (drainLeft == 0) begin
                draining = 0;
                halted   = 1;
            end
        end else if (v) begin
            if (mCount != 32'hFFFF_FFFF) mCount = mCount + 1;
            if (s >= NSRC) mErr = 1;
            mWe = 0;
            if (h) begin
                draining  = 1;
                drainLeft = DRAIN;
            end else if (rw && rd != 0 && s < NSRC) begin
                mWe   = 1;
                mRd   = rd;
                mData = data[s*32 +: 32];
            end
        end else begin
            mWe = 0;
        end
    endtask

    task automatic checkOutput(input string tag);
        #1;
        vectors++;
        assert (wbWe === mWe) else begin
            miscompares++;
            $error("[TB] FAIL %s wbWe observed=%0h expected=%0h", tag, wbWe, mWe);
        end
        vectors++;
        assert (wbRd === mRd) else begin
            miscompares++;
            $error("[TB] FAIL %s wbRd observed=%0h expected=%0h", tag, wbRd, mRd);
        end
        vectors++;
        assert (wbData === mData) else begin
            miscompares++;
            $error("[TB] FAIL %s wbData observed=%0h expected=%0h", tag, wbData, mData);
        end
        vectors++;
        assert (retireCount === mCount) else begin
            miscompares++;
            $error("[TB] FAIL %s retireCount observed=%0h expected=%0h", tag, retireCount, mCount);
        end
        vectors++;
        assert (selError === mErr) else begin
            miscompares++;
            $error("[TB] FAIL %s selError observed=%0h expected=%0h", tag, selError, mErr);
        end
        vectors++;
        assert (haltDone === halted) else begin
            miscompares++;
            $error("[TB] FAIL %s haltDone observed=%0h expected=%0h", tag, haltDone, halted);
        end
    endtask

    task automatic randomRun(input int n, input int selMax, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 1'b0,
                          5'($urandom_range(0, 31)), 2'($urandom_range(0, selMax)),
                          {$urandom, $urandom, $urandom});
            checkOutput(tag);
        end
    endtask

    initial begin
        resetN = 0; inValid = 0; inRd = '0; inRegWrite = 0; inSel = '0; inData = '0; inHalt = 0;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 96'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 2'd0, 96'd0);
        checkOutput("reset");

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 2'd1, {32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222});
        checkOutput("firstWrite");

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 2'd2, {$urandom, $urandom, $urandom});
        checkOutput("rdZero");

        randomRun(30, 2, "randValid");

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 2'd3, {$urandom, $urandom, $urandom});
        checkOutput("selOutOfRange");
        randomRun(20, 3, "randStickyErr");

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 2'd0, 96'd0);
        checkOutput("resetClearsErr");
        randomRun(10, 2, "randAfterReset");

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 2'd0, {$urandom, $urandom, $urandom});
        checkOutput("haltAccept");
        for (int i = 0; i < DRAIN; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 2'd1, {$urandom, $urandom, $urandom});
            checkOutput("drainCycle");
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 2'd0, {$urandom, $urandom, $urandom});
            checkOutput("haltedSticky");
        end

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 96'd0);
        checkOutput("resetFromHalted");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 2'd0, 96'd0);
        checkOutput("haltAgain");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 2'd0, {$urandom, $urandom, $urandom});
        checkOutput("drainBeforeReset");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 2'd0, {$urandom, $urandom, $urandom});
        checkOutput("resetInDrain");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 2'd2, {32'hCAFE_F00D, $urandom, $urandom});
        checkOutput("firstAfterRelease");

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 96'd0);
        checkOutput("idle");
        @(negedge clk);
        force dut.retireCount = 32'hFFFF_FFFE;
        #1;
        release dut.retireCount;
        mCount = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'(i + 1), 2'd0, {$urandom, $urandom, $urandom});
            checkOutput("saturate");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
